// File: rtl/spi_master_multi.sv
// Multi-slave SPI master: per-transfer CPOL/CPHA, divided SCLK and an
// internal MISO mux, with a start/busy/done handshake and select checking.
module spi_master_multi #(
   parameter int DATA_W     = 8,
   parameter int NUM_SLAVES = 3,
   parameter int SEL_W      = 2,
   parameter int CLK_DIV    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [SEL_W-1:0]      slave_sel,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic [DATA_W-1:0]     tx_data,
   input  logic [NUM_SLAVES-1:0] miso,
   output logic                  sclk,
   output logic                  mosi,
   output logic [NUM_SLAVES-1:0] cs_n,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [DATA_W-1:0]     rx_data
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGE_W = $clog2(2 * DATA_W);
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} state_t;

   state_t                state;
   logic [DIV_W-1:0]      div_cnt;
   logic [EDGE_W-1:0]     edge_cnt;
   logic [SEL_W-1:0]      sel_q;
   logic                  cpol_q;
   logic                  cpha_q;
   logic [DATA_W-1:0]     tx_sh;
   logic [DATA_W-1:0]     rx_sh;
   logic [NUM_SLAVES-1:0] cs_dec;
   logic                  miso_bit;
   logic                  sel_ok;
   logic                  div_end;
   logic                  lead_edge;

   always_comb begin
      miso_bit = 1'b0;
      cs_dec   = '1;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q == SEL_W'(i)) miso_bit = miso[i];
         if (slave_sel == SEL_W'(i)) cs_dec[i] = 1'b0;
      end
   end

   assign sel_ok    = 32'(slave_sel) < 32'(NUM_SLAVES);
   assign div_end   = div_cnt == DIV_W'(CLK_DIV - 1);
   // Even edge numbers move SCLK away from its idle level.
   assign lead_edge = ~edge_cnt[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         div_cnt  <= '0;
         edge_cnt <= '0;
         sel_q    <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cs_n     <= '1;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         rx_data  <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               sclk     <= cpol;
               mosi     <= 1'b0;
               cs_n     <= '1;
               div_cnt  <= '0;
               edge_cnt <= '0;
               if (start && sel_ok) begin
                  state  <= LEAD;
                  busy   <= 1'b1;
                  sel_q  <= slave_sel;
                  cpol_q <= cpol;
                  cpha_q <= cpha;
                  tx_sh  <= tx_data;
                  cs_n   <= cs_dec;
                  mosi   <= cpha ? 1'b0 : tx_data[DATA_W-1];
               end else if (start) begin
                  err <= 1'b1;
               end
            end
            LEAD: begin
               div_cnt <= div_end ? '0 : div_cnt + 1'b1;
               if (div_end) state <= SHIFT;
            end
            SHIFT: begin
               div_cnt <= div_end ? '0 : div_cnt + 1'b1;
               if (div_end) begin
                  sclk     <= ~sclk;
                  edge_cnt <= edge_cnt + 1'b1;
                  if (lead_edge != cpha_q) begin
                     rx_sh <= {rx_sh[DATA_W-2:0], miso_bit};
                  end else if (cpha_q) begin
                     mosi  <= tx_sh[DATA_W-1];
                     tx_sh <= tx_sh << 1;
                  end else if (edge_cnt != LAST_EDGE) begin
                     mosi  <= tx_sh[DATA_W-2];
                     tx_sh <= tx_sh << 1;
                  end
                  if (edge_cnt == LAST_EDGE) state <= TRAIL;
               end
            end
            TRAIL: begin
               div_cnt <= div_end ? '0 : div_cnt + 1'b1;
               if (div_end) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  rx_data <= rx_sh;
                  cs_n    <= '1;
                  mosi    <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               sclk  <= cpol_q;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: default 8-bit instance with loopback
// and a mode-3 slave model, plus a 16-bit CLK_DIV=1 loopback instance.
module tb_spi_master_multi;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] slave_sel = 2'd0;
   logic       cpol = 1'b0;
   logic       cpha = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [2:0] miso;
   logic       sclk, mosi, busy, done, err;
   logic [2:0] cs_n;
   logic [7:0] rx_data;

   logic        start16 = 1'b0;
   logic [1:0]  sel16 = 2'd0;
   logic        cpol16 = 1'b0;
   logic        cpha16 = 1'b0;
   logic [15:0] tx16 = 16'h0000;
   logic [2:0]  miso16;
   logic        sclk16, mosi16, busy16, done16, err16;
   logic [2:0]  cs16;
   logic [15:0] rx16;

   int total = 0;
   int bad = 0;

   // Mode-3 slave on select 2: drives on falling, captures on rising.
   logic       s_out = 1'b0;
   int         s_idx = 7;
   logic [7:0] s_word = 8'h3C;
   logic [7:0] s_rx = 8'h00;

   always #5 clk = ~clk;

   assign miso   = {s_out, mosi, mosi};
   assign miso16 = {2'b00, mosi16};

   always @(negedge sclk or posedge cs_n[2]) begin
      if (cs_n[2] === 1'b1) begin
         s_idx <= 7;
      end else if (s_idx >= 0) begin
         s_out <= s_word[s_idx];
         s_idx <= s_idx - 1;
      end
   end

   always @(posedge sclk) begin
      if (cs_n[2] === 1'b0) s_rx <= {s_rx[6:0], mosi};
   end

   spi_master_multi dut (
      .clk(clk), .rst(rst), .start(start), .slave_sel(slave_sel),
      .cpol(cpol), .cpha(cpha), .tx_data(tx_data), .miso(miso),
      .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy),
      .done(done), .err(err), .rx_data(rx_data)
   );

   spi_master_multi #(
      .DATA_W(16), .NUM_SLAVES(3), .SEL_W(2), .CLK_DIV(1)
   ) dut16 (
      .clk(clk), .rst(rst), .start(start16), .slave_sel(sel16),
      .cpol(cpol16), .cpha(cpha16), .tx_data(tx16), .miso(miso16),
      .sclk(sclk16), .mosi(mosi16), .cs_n(cs16), .busy(busy16),
      .done(done16), .err(err16), .rx_data(rx16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called one cycle after the accepting edge; returns the done cycle.
   task automatic wait_done(input bit wide, output int cyc);
      cyc = 1;
      while (((wide ? done16 : done) !== 1'b1) && cyc < 200) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      total++; if (cs_n !== 3'b111) begin bad++; $display("FAIL reset_cs_n got=%b want=111", cs_n); end
      total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", sclk); end
      total++; if (mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b want=0", mosi); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx got=%h want=00", rx_data); end
      total++; if (cs16 !== 3'b111) begin bad++; $display("FAIL reset_cs16 got=%b want=111", cs16); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_mode0();
      int cyc;
      int rises;
      logic prev;
      bit cs_ok;
      slave_sel = 2'd1; cpol = 1'b0; cpha = 1'b0; tx_data = 8'hA5;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1; rises = 0; prev = sclk; cs_ok = 1'b1;
      while (done !== 1'b1 && cyc < 200) begin
         if (cs_n !== 3'b101) cs_ok = 1'b0;
         tick();
         cyc++;
         if (sclk === 1'b1 && prev === 1'b0) rises++;
         prev = sclk;
      end
      total++; if (cyc != 37) begin bad++; $display("FAIL m0_done_cycle got=%0d want=37", cyc); end
      total++; if (!cs_ok) begin bad++; $display("FAIL m0_cs_n got=not_101 want=101"); end
      total++; if (rises != 8) begin bad++; $display("FAIL m0_rises got=%0d want=8", rises); end
      total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL m0_rx got=%h want=a5", rx_data); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL m0_busy_done got=%b want=1", busy); end
      total++; if (cs_n !== 3'b111) begin bad++; $display("FAIL m0_cs_done got=%b want=111", cs_n); end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL m0_busy_after got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL m0_done_pulse got=%b want=0", done); end
   endtask

   task automatic test_mode3();
      int cyc;
      cpol = 1'b1; cpha = 1'b1;
      repeat (2) tick();
      total++; if (sclk !== 1'b1) begin bad++; $display("FAIL m3_idle_before got=%b want=1", sclk); end
      slave_sel = 2'd2; tx_data = 8'hC3;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 200) begin
         if (cyc == 5) begin
            cpol = 1'b0; cpha = 1'b0; slave_sel = 2'd0; tx_data = 8'h00;
         end
         if (cyc == 20) cpol = 1'b1;
         tick();
         cyc++;
      end
      total++; if (cyc != 37) begin bad++; $display("FAIL m3_done_cycle got=%0d want=37", cyc); end
      total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL m3_rx got=%h want=3c", rx_data); end
      total++; if (s_rx !== 8'hC3) begin bad++; $display("FAIL m3_slave_rx got=%h want=c3", s_rx); end
      total++; if (sclk !== 1'b1) begin bad++; $display("FAIL m3_sclk_done got=%b want=1", sclk); end
      repeat (2) tick();
      total++; if (sclk !== 1'b1) begin bad++; $display("FAIL m3_idle_after got=%b want=1", sclk); end
      cpol = 1'b0; cpha = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_wide();
      int cyc;
      logic [2:0]  md [3] = '{3'd1, 3'd2, 3'd2};
      logic [15:0] tv [3] = '{16'h8001, 16'h8001, 16'h1234};
      for (int i = 0; i < 3; i++) begin
         cpol16 = md[i][1]; cpha16 = md[i][0];
         repeat (2) tick();
         tx16 = tv[i];
         start16 = 1'b1;
         tick();
         start16 = 1'b0;
         tx16 = 16'hFFFF;
         wait_done(1'b1, cyc);
         total++; if (cyc != 35) begin bad++; $display("FAIL wide%0d_done_cycle got=%0d want=35", i, cyc); end
         total++; if (rx16 !== tv[i]) begin bad++; $display("FAIL wide%0d_rx got=%h want=%h", i, rx16, tv[i]); end
         total++; if (busy16 !== 1'b1 || cs16 !== 3'b111) begin bad++; $display("FAIL wide%0d_done_state got=%b/%b want=1/111", i, busy16, cs16); end
         tick();
         total++; if (sclk16 !== md[i][1]) begin bad++; $display("FAIL wide%0d_idle got=%b want=%b", i, sclk16, md[i][1]); end
      end
      total++; if (err16 !== 1'b0) begin bad++; $display("FAIL wide_err got=%b want=0", err16); end
   endtask

   task automatic test_invalid();
      int toggles;
      logic prev;
      cpol = 1'b0;
      repeat (2) tick();
      slave_sel = 2'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL inv_err got=%b want=1", err); end
      total++; if (cs_n !== 3'b111) begin bad++; $display("FAIL inv_cs_n got=%b want=111", cs_n); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL inv_busy got=%b want=0", busy); end
      toggles = 0; prev = sclk;
      tick();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL inv_err_pulse got=%b want=0", err); end
      for (int i = 0; i < 6; i++) begin
         if (sclk !== prev) toggles++;
         prev = sclk;
         tick();
      end
      total++; if (toggles != 0 || cs_n !== 3'b111) begin bad++; $display("FAIL inv_quiet got=%0d/%b want=0/111", toggles, cs_n); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      int gap;
      int bound;
      logic busy_idle;
      slave_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; tx_data = 8'h12;
      start = 1'b1;
      tick();
      tx_data = 8'h34;
      wait_done(1'b0, cyc);
      total++; if (rx_data !== 8'h12) begin bad++; $display("FAIL b2b_rx1 got=%h want=12", rx_data); end
      gap = 0; bound = 0; busy_idle = 1'bx;
      while (cs_n[0] === 1'b1 && bound < 10) begin
         gap++;
         tick();
         bound++;
         if (bound == 1) busy_idle = busy;
      end
      start = 1'b0;
      total++; if (gap != 2) begin bad++; $display("FAIL b2b_gap got=%0d want=2", gap); end
      total++; if (busy_idle !== 1'b0) begin bad++; $display("FAIL b2b_busy_idle got=%b want=0", busy_idle); end
      wait_done(1'b0, cyc);
      total++; if (cyc != 37) begin bad++; $display("FAIL b2b_done_cycle got=%0d want=37", cyc); end
      total++; if (rx_data !== 8'h34) begin bad++; $display("FAIL b2b_rx2 got=%h want=34", rx_data); end
      repeat (2) tick();
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit seen;
      slave_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; tx_data = 8'hF0;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      while (cyc < 16) begin
         tick();
         cyc++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (cs_n !== 3'b111 || sclk !== 1'b0 || mosi !== 1'b0) begin bad++; $display("FAIL rmid_pins got=%b/%b/%b want=111/0/0", cs_n, sclk, mosi); end
      total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rmid_flags got=%b%b%b want=000", busy, done, err); end
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rmid_rx got=%h want=00", rx_data); end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1) seen = 1'b1;
      end
      total++; if (seen) begin bad++; $display("FAIL rmid_no_done got=1 want=0"); end
      tx_data = 8'h5A;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(1'b0, cyc);
      total++; if (cyc != 37) begin bad++; $display("FAIL rmid_done_cycle got=%0d want=37", cyc); end
      total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL rmid_rx2 got=%h want=5a", rx_data); end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_mode0();
      test_mode3();
      test_wide();
      test_invalid();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
